// File: rtl/alu_hs.sv
// Handshaked ALU: add/sub/mul complete in one cycle, unsigned division runs a
// restoring divider for WIDTH cycles and returns {remainder, quotient}.
module alu_hs #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           oper,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 div_by_zero,
   output logic                 busy
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, DIV} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt_p0;
   logic [WIDTH-1:0]    quo_p0;
   logic [WIDTH-1:0]    rem_p0;
   logic [WIDTH-1:0]    dvs_p0;
   logic [2*WIDTH-1:0]  div_nxt;
   logic                accept;
   logic                div_start;

   function automatic logic [2*WIDTH-1:0] alu_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = '0;
      case (op)
         2'b00: begin
            s = {1'b0, a} + {1'b0, b};
            return {{(WIDTH-1){1'b0}}, s};
         end
         2'b01: return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
         2'b10: begin
            s = {1'b0, a} - {1'b0, b};
            return {{(WIDTH-1){1'b0}}, s};
         end
         default: return '0;
      endcase
   endfunction

   // One restoring step: returns {remainder, quotient} after shifting in the next dividend bit.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] quo,
                                                   input logic [WIDTH-1:0] dvs);
      logic [WIDTH:0]   sh;
      logic [WIDTH+1:0] trial;
      sh    = {rem, quo[WIDTH-1]};
      trial = {1'b0, sh} - {2'b00, dvs};
      if (trial[WIDTH+1])
         return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
      else
         return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
   endfunction

   assign in_ready  = rst && (state == IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign div_start = (oper == 2'b11) && (in2 != '0);
   assign div_nxt   = div_step(rem_p0, quo_p0, dvs_p0);

   // Stage p0: divider working registers, captured on a division accept
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (accept) begin
            quo_p0 <= in1;
            dvs_p0 <= in2;
            rem_p0 <= '0;
         end
      end else begin
         {rem_p0, quo_p0} <= div_nxt;
      end
   end

   // Stage p1: result register and handshake control
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt_p0      <= '0;
         out         <= '0;
         out_valid   <= 1'b0;
         div_by_zero <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (div_start) begin
                     state     <= DIV;
                     busy      <= 1'b1;
                     cnt_p0    <= '0;
                     out_valid <= 1'b0;
                  end else begin
                     out         <= alu_op(oper, in1, in2);
                     div_by_zero <= (oper == 2'b11);
                     out_valid   <= 1'b1;
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DIV: begin
               cnt_p0 <= cnt_p0 + 1'b1;
               if (cnt_p0 == LAST) begin
                  out         <= div_nxt;
                  div_by_zero <= 1'b0;
                  out_valid   <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_hs.sv
// Scoreboard bench for alu_hs (WIDTH=4): directed handshake scenarios plus a
// randomised stream with random backpressure.
module tb_alu_hs;

   localparam int W  = 4;
   localparam int RW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    oper = 2'b00;
   logic [W-1:0]  in1 = '0;
   logic [W-1:0]  in2 = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [RW-1:0] out;
   logic          div_by_zero;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [RW-1:0] val;
      logic          dbz;
   } exp_t;

   exp_t sbq[$];

   alu_hs #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .oper(oper), .in1(in1), .in2(in2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .div_by_zero(div_by_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [1:0] op, input int a, input int b);
      exp_t e;
      e.dbz = 1'b0;
      case (op)
         2'd0: e.val = RW'(a + b);
         2'd1: e.val = RW'(a * b);
         2'd2: e.val = RW'((a - b + 32) % 32);
         default: begin
            if (b == 0) begin
               e.val = '0;
               e.dbz = 1'b1;
            end else begin
               e.val = RW'(((a % b) << W) | (a / b));
            end
         end
      endcase
      return e;
   endfunction

   // Present an operation and record its expected result; caller ensures in_ready.
   task automatic drive(input logic [1:0] op, input int a, input int b);
      in_valid = 1'b1;
      oper     = op;
      in1      = W'(a);
      in2      = W'(b);
      sbq.push_back(model(op, a, b));
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out !== '0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b busy=%b out=%0h dbz=%b required 0 0 0 0",
                  out_valid, busy, out, div_by_zero);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b required 0", in_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_reset_mid_div;
      int stray;
      out_ready = 1'b1;
      @(negedge clk);
      drive(2'd3, 13, 3);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL middiv_busy: got %b required 1", busy);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL middiv_reset: out_valid=%b busy=%b in_ready=%b required 0 0 0",
                  out_valid, busy, in_ready);
      end
      sbq.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL middiv_ready: got %b required 1", in_ready);
      end
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) stray++;
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL middiv_stray: got %0d valid cycles required 0", stray);
      end
   endtask

   task automatic test_add_mul;
      exp_t e;
      out_ready = 1'b1;
      @(negedge clk);
      drive(2'd0, 15, 15);
      @(negedge clk);
      drive(2'd1, 15, 15);
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL add_15_15: valid=%b out=%0h dbz=%b required 1 %0h %b",
                  out_valid, out, div_by_zero, e.val, e.dbz);
      end
      @(negedge clk);
      in_valid = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL mul_15_15: valid=%b out=%0h dbz=%b required 1 %0h %b",
                  out_valid, out, div_by_zero, e.val, e.dbz);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_mul_drain: valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_sub;
      exp_t e;
      out_ready = 1'b1;
      @(negedge clk);
      drive(2'd2, 3, 5);
      @(negedge clk);
      drive(2'd2, 9, 4);
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL sub_3_5: valid=%b out=%0h dbz=%b required 1 %0h %b",
                  out_valid, out, div_by_zero, e.val, e.dbz);
      end
      @(negedge clk);
      in_valid = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL sub_9_4: valid=%b out=%0h dbz=%b required 1 %0h %b",
                  out_valid, out, div_by_zero, e.val, e.dbz);
      end
      @(negedge clk);
   endtask

   task automatic test_div;
      exp_t e;
      int lat, busy_cyc, ready_bad;
      out_ready = 1'b1;
      @(negedge clk);
      drive(2'd3, 13, 3);
      lat = 0; busy_cyc = 0; ready_bad = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
         if (busy) busy_cyc++;
         if (busy && in_ready) ready_bad++;
      end while (!out_valid && lat < 20);
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL div_latency: got %0d cycles required 5", lat);
      end
      checks++;
      if (busy_cyc !== 4 || ready_bad !== 0) begin
         errors++;
         $display("FAIL div_busy: busy cycles %0d ready-while-busy %0d required 4 0",
                  busy_cyc, ready_bad);
      end
      e = sbq.pop_front();
      checks++;
      if (out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL div_13_3: out=%0h dbz=%b required %0h %b", out, div_by_zero, e.val, e.dbz);
      end
      drive(2'd3, 7, 0);
      @(negedge clk);
      in_valid = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL div_7_0: valid=%b out=%0h dbz=%b required 1 %0h %b",
                  out_valid, out, div_by_zero, e.val, e.dbz);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      exp_t e;
      int unstable;
      out_ready = 1'b0;
      @(negedge clk);
      drive(2'd0, 15, 15);
      @(negedge clk);
      in_valid = 1'b0;
      unstable = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out !== RW'(30) || in_ready !== 1'b0) unstable++;
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("FAIL bp_hold: got %0d unstable cycles required 0", unstable);
      end
      out_ready = 1'b1;
      drive(2'd1, 2, 3);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready: got %b required 1", in_ready);
      end
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val) begin
         errors++;
         $display("FAIL bp_retire: valid=%b out=%0h required 1 %0h", out_valid, out, e.val);
      end
      @(negedge clk);
      in_valid = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL bp_mul_2_3: valid=%b out=%0h required 1 %0h", out_valid, out, e.val);
      end
      @(negedge clk);
   endtask

   task automatic test_operand_hold;
      exp_t e;
      int lat;
      out_ready = 1'b1;
      @(negedge clk);
      drive(2'd3, 14, 4);
      @(negedge clk);
      in_valid = 1'b0;
      in1 = 4'd1;
      in2 = 4'd1;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         in1 = W'($urandom);
         in2 = W'($urandom);
         lat++;
      end
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.val || div_by_zero !== e.dbz) begin
         errors++;
         $display("FAIL hold_div_14_4: valid=%b out=%0h required 1 %0h", out_valid, out, e.val);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int bad, budget;
      logic [1:0] op;
      int a, b;
      bad = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               bad++;
               $display("FAIL rand_stray: out=%0h with empty scoreboard", out);
            end else begin
               e = sbq.pop_front();
               checks++;
               if (out !== e.val || div_by_zero !== e.dbz) begin
                  errors++;
                  $display("FAIL rand_result: out=%0h dbz=%b required %0h %b",
                           out, div_by_zero, e.val, e.dbz);
               end
            end
         end
         op = 2'($urandom);
         a  = int'($urandom_range(0, 15));
         b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15));
         in_valid = ($urandom_range(0, 2) != 0);
         oper = op;
         in1  = W'(a);
         in2  = W'(b);
         #1;
         if (in_valid && in_ready) sbq.push_back(model(op, a, b));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      budget = 0;
      while (sbq.size() != 0 && budget < 50) begin
         #1;
         if (out_valid) begin
            e = sbq.pop_front();
            checks++;
            if (out !== e.val || div_by_zero !== e.dbz) begin
               errors++;
               $display("FAIL rand_drain: out=%0h dbz=%b required %0h %b",
                        out, div_by_zero, e.val, e.dbz);
            end
         end
         @(negedge clk);
         budget++;
      end
      checks++;
      if (sbq.size() != 0 || bad != 0) begin
         errors++;
         $display("FAIL rand_scoreboard: %0d results missing, %0d stray", sbq.size(), bad);
      end
   endtask

   initial begin
      test_reset;
      test_reset_mid_div;
      test_add_mul;
      test_sub;
      test_div;
      test_backpressure;
      test_operand_hold;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
